// File: rtl/state_pkg.sv
// Shared animation-state encoding consumed by draw_player_1.
package state_pkg;
  typedef enum logic [1:0] {IDLE1 = 2'd0, RIGHT1 = 2'd1, LEFT1 = 2'd2} State1;
endpackage

// File: rtl/player_ctl_1_if.sv
// Button inputs and sprite position/animation outputs for player 1.
interface player_ctl_1_if;
  import state_pkg::*;

  logic        frame_tick;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [11:0] xpos_player1;
  logic [11:0] yoff_player1;
  State1       state;
  logic        jumping;

  modport master (
    output frame_tick, btn_left, btn_right, btn_jump,
    input  xpos_player1, yoff_player1, state, jumping
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_jump,
    output xpos_player1, yoff_player1, state, jumping
  );
endinterface

// File: rtl/player_ctl_1.sv
// Frame-paced horizontal motion and jump FSM for player 1.
// Optional button synchronizers: define PLAYER_CTL_INPUT_SYNC_EN.
module player_ctl_1 #(
  parameter int unsigned X_INIT      = 100,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 760,
  parameter int unsigned X_STEP      = 2,
  parameter int unsigned JUMP_HEIGHT = 60,
  parameter int unsigned JUMP_STEP   = 3
) (
  input logic             clk,
  input logic             rst,
  player_ctl_1_if.slave   bus
);
  import state_pkg::*;

  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] FALL   = 2'd2;

  logic btn_left_s, btn_right_s, btn_jump_s;

`ifdef PLAYER_CTL_INPUT_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.btn_jump, bus.btn_right, bus.btn_left};
      sync2_q <= sync1_q;
    end
  end

  assign {btn_jump_s, btn_right_s, btn_left_s} = sync2_q;
`else
  assign btn_left_s  = bus.btn_left;
  assign btn_right_s = bus.btn_right;
  assign btn_jump_s  = bus.btn_jump;
`endif

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  State1       st_q, st_d;
  logic [1:0]  fsm_q, fsm_d;
  logic        jumping_q;
  logic [12:0] x_wide, y_wide;

  // Horizontal: 13-bit math so the clamp sees overflow/underflow instead of wrap.
  always_comb begin
    x_d    = x_q;
    st_d   = st_q;
    x_wide = '0;
    if (bus.frame_tick) begin
      if (btn_right_s && !btn_left_s) begin
        st_d   = RIGHT1;
        x_wide = {1'b0, x_q} + 13'(X_STEP);
        x_d    = (x_wide > 13'(X_MAX)) ? 12'(X_MAX) : x_wide[11:0];
      end else if (btn_left_s && !btn_right_s) begin
        st_d   = LEFT1;
        x_wide = {1'b0, x_q} - 13'(X_STEP);
        x_d    = ({1'b0, x_q} < 13'(X_MIN) + 13'(X_STEP)) ? 12'(X_MIN) : x_wide[11:0];
      end else begin
        st_d   = IDLE1;
      end
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    y_d    = y_q;
    y_wide = {1'b0, y_q} + 13'(JUMP_STEP);
    if (bus.frame_tick) begin
      case (fsm_q)
        GROUND: begin
          if (btn_jump_s) begin
            fsm_d = RISE;
            y_d   = (JUMP_STEP >= JUMP_HEIGHT) ? 12'(JUMP_HEIGHT) : 12'(JUMP_STEP);
          end else begin
            y_d   = '0;
          end
        end
        RISE: begin
          if (y_wide >= 13'(JUMP_HEIGHT)) begin
            fsm_d = FALL;
            y_d   = 12'(JUMP_HEIGHT);
          end else begin
            y_d   = y_wide[11:0];
          end
        end
        FALL: begin
          if (y_q <= 12'(JUMP_STEP)) begin
            fsm_d = GROUND;
            y_d   = '0;
          end else begin
            y_d   = y_q - 12'(JUMP_STEP);
          end
        end
        default: begin
          fsm_d = GROUND;
          y_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= 12'(X_INIT);
      y_q       <= '0;
      st_q      <= IDLE1;
      fsm_q     <= GROUND;
      jumping_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      st_q      <= st_d;
      fsm_q     <= fsm_d;
      jumping_q <= (fsm_d != GROUND);
    end
  end

  assign bus.xpos_player1 = x_q;
  assign bus.yoff_player1 = y_q;
  assign bus.state        = st_q;
  assign bus.jumping      = jumping_q;

endmodule

// File: tb/tb_player_ctl_1.sv
// Randomized bench for player_ctl_1 against a frame-count behavioural model.
module tb_player_ctl_1;
  import state_pkg::*;

  localparam int XI = 100, XMN = 0, XMX = 760, XS = 2, JH = 60, JS = 3;
  localparam int RISE_N = (JH + JS - 1) / JS;
  localparam int FALL_N = (JH + JS - 1) / JS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  player_ctl_1_if bus ();

  player_ctl_1 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model: x as plain int, jump as "frames since take-off" (0 = on ground).
  int    m_x = XI;
  int    m_k = 0;
  State1 m_st = IDLE1;

  function automatic int height(input int k);
    if (k == 0) return 0;
    if (k <= RISE_N) return (k * JS > JH) ? JH : k * JS;
    return (JH - (k - RISE_N) * JS < 0) ? 0 : JH - (k - RISE_N) * JS;
  endfunction

  function automatic int next_k(input int k, input logic jmp);
    if (k == 0) return jmp ? 1 : 0;
    if (k + 1 >= RISE_N + FALL_N) return 0;
    return k + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_x  <= XI;
      m_k  <= 0;
      m_st <= IDLE1;
    end else if (bus.frame_tick) begin
      m_k <= next_k(m_k, bus.btn_jump);
      if (bus.btn_right && !bus.btn_left) begin
        m_st <= RIGHT1;
        m_x  <= (m_x + XS > XMX) ? XMX : m_x + XS;
      end else if (bus.btn_left && !bus.btn_right) begin
        m_st <= LEFT1;
        m_x  <= (m_x - XS < XMN) ? XMN : m_x - XS;
      end else begin
        m_st <= IDLE1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (int'(bus.xpos_player1) != m_x || int'(bus.yoff_player1) != height(m_k) ||
          bus.state != m_st || bus.jumping != (m_k != 0)) begin
        n_errors++;
        $display("FAIL cycle_model t=%0t: got x=%0d y=%0d st=%0d j=%0d, want x=%0d y=%0d st=%0d j=%0d",
                 $time, bus.xpos_player1, bus.yoff_player1, bus.state, bus.jumping,
                 m_x, height(m_k), m_st, (m_k != 0));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic l, input logic r, input logic j);
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_jump  = j;
  endtask

  // One tick: pulse frame_tick for one cycle, return 2 time units after the edge that used it.
  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2 bus.frame_tick = 1'b1;
      @(posedge clk); #2 bus.frame_tick = 1'b0;
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    do_tick(5);
    chk("idle_x", bus.xpos_player1, 100);
    chk("idle_y", bus.yoff_player1, 0);
    chk("idle_state", bus.state, IDLE1);
    chk("idle_jumping", bus.jumping, 0);

    set_btn(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      do_tick(1);
      chk("right_x", bus.xpos_player1, 100 + 2 * i);
      chk("right_state", bus.state, RIGHT1);
    end
    set_btn(1'b0, 1'b0, 1'b0);
    do_tick(1);
    chk("release_state", bus.state, IDLE1);
    repeat (5) @(posedge clk);
    chk("hold_x", bus.xpos_player1, 106);

    set_btn(1'b1, 1'b1, 1'b0);
    do_tick(4);
    chk("both_x", bus.xpos_player1, 106);
    chk("both_state", bus.state, IDLE1);

    set_btn(1'b0, 1'b0, 1'b1);
    do_tick(1);
    set_btn(1'b0, 1'b0, 1'b0);
    chk("jump_first_y", bus.yoff_player1, 3);
    chk("jump_first_j", bus.jumping, 1);
    for (int t = 2; t <= 40; t++) begin
      bus.btn_jump = ($urandom_range(0, 1) == 1);
      do_tick(1);
      if (t == 20) chk("apex_y", bus.yoff_player1, 60);
      if (t == 39) chk("last_air_j", bus.jumping, 1);
    end
    bus.btn_jump = 1'b0;
    chk("land_y", bus.yoff_player1, 0);
    chk("land_j", bus.jumping, 0);

    bus.btn_jump = 1'b1;
    do_tick(1);
    bus.btn_jump = 1'b0;
    do_tick(9);
    chk("midrise_y", bus.yoff_player1, 30);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    chk("rst_y", bus.yoff_player1, 0);
    chk("rst_x", bus.xpos_player1, 100);
    chk("rst_state", bus.state, IDLE1);
    chk("rst_j", bus.jumping, 0);

    bus.btn_jump = 1'b1;
    do_tick(40);
    chk("held_ground_y", bus.yoff_player1, 0);
    chk("held_ground_j", bus.jumping, 0);
    do_tick(1);
    chk("held_retrig_y", bus.yoff_player1, 3);

    set_btn(1'b0, 1'b1, 1'b0);
    do_tick(340);
    chk("clamp_max_x", bus.xpos_player1, 760);
    chk("clamp_max_state", bus.state, RIGHT1);
    set_btn(1'b1, 1'b0, 1'b0);
    do_tick(400);
    chk("clamp_min_x", bus.xpos_player1, 0);
    chk("clamp_min_state", bus.state, LEFT1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      set_btn(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 3) == 0));
      rst = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    bus.frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/player_ctl_1.md
Name: player_ctl_1

Overview:
- Frame-paced motion controller for player 1.
- Turns button inputs into the position and animation state consumed by draw_player_1: xpos_player1, vertical jump offset, and the State1 value.
- Updates once per video frame on a one-cycle frame_tick pulse, so movement speed is independent of clk.
- Owns horizontal clamping and the jump state machine; the draw block stays purely combinational.

Parameters:
- X_INIT, 100: xpos_player1 after reset.
- X_MIN, 0: minimum xpos_player1.
- X_MAX, 760: maximum xpos_player1 (screen width 800 minus sprite width 40).
- X_STEP, 2: horizontal pixels moved per frame.
- JUMP_HEIGHT, 60: apex height in pixels.
- JUMP_STEP, 3: vertical pixels moved per frame while rising or falling.

Ports:
- clk  input  1  pixel clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- frame_tick  input  1  one-cycle pulse per frame (start of vblank)
- btn_left  input  1  move-left request, level
- btn_right  input  1  move-right request, level
- btn_jump  input  1  jump request, level
- xpos_player1  output  12  sprite left edge, pixels
- yoff_player1  output  12  height above floor, pixels, unsigned, 0 = standing
- state  output  State1  IDLE1 / RIGHT1 / LEFT1, from state_pkg
- jumping  output  1  high while the jump FSM is not in GROUND

Behaviour:
- All outputs are registered. They change only in the cycle after a clk edge where frame_tick=1; otherwise they hold.
- Latency: button sampled at the tick edge, new outputs visible 1 clk later.
- Reset values: xpos_player1=X_INIT, yoff_player1=0, state=IDLE1, jumping=0, jump FSM=GROUND.
- Reset mid-jump returns immediately to GROUND with yoff=0.
- Horizontal, on each tick:
  - right only: state=RIGHT1, x=min(x+X_STEP, X_MAX).
  - left only: state=LEFT1, x=max(x-X_STEP, X_MIN). Use 13-bit intermediate arithmetic; no wrap-around below 0.
  - neither or both pressed: state=IDLE1, x unchanged.
  - At a limit with the button held, state still reports the direction (RIGHT1/LEFT1) and x holds at the limit.
- Jump FSM, states GROUND, RISE, FALL, evaluated only on a tick:
  - GROUND: if btn_jump, go to RISE and set y=min(JUMP_STEP, JUMP_HEIGHT); else y=0.
  - RISE: y=y+JUMP_STEP. If the result is at or above JUMP_HEIGHT, y=JUMP_HEIGHT (saturate) and go to FALL.
  - FALL: y=y-JUMP_STEP. If the result is at or below 0, y=0 and go to GROUND.
  - btn_jump is ignored in RISE and FALL.
  - A held btn_jump re-triggers on the first tick spent in GROUND after landing, so there is exactly one ground frame between jumps.
- Horizontal movement and jump are independent; both apply on the same tick.
- jumping = (FSM != GROUND), registered with the FSM.
- Buttons are treated as synchronous to clk unless the optional feature below is compiled in.

Optional Feature:
- Macro: PLAYER_CTL_INPUT_SYNC_EN.
- Defined: btn_left/btn_right/btn_jump each pass through a 2-flop synchronizer (reset to 0) before use. A press must be stable 2 clk before a tick to be seen at that tick.
- Undefined: buttons are sampled directly, with no added latency.

Test Plan:
- Reset released, 5 ticks with no buttons -> x=100, yoff=0, state=IDLE1, jumping=0.
- btn_right held for 3 ticks -> x=102, 104, 106 with state=RIGHT1. Release, then 1 tick -> state=IDLE1, x=106. No change between ticks.
- Start x=759, btn_right, 2 ticks -> x=760, 760, state=RIGHT1. Start x=1, btn_left, 2 ticks -> x=0, 0, state=LEFT1.
- btn_left and btn_right together for 4 ticks -> x unchanged, state=IDLE1.
- btn_jump pulsed for 1 tick, then ticks continue -> yoff 3, 6, …, 57, 60 (apex at tick 20), then 57, …, 3, 0 (ground at tick 40). jumping high for ticks 1–39 and low after the tick-40 update. A jump press during ticks 2–39 has no effect.
- Mid-RISE (yoff=30) assert rst for 1 clk -> next clk yoff=0, x=100, state=IDLE1, jumping=0.
- With btn_jump held continuously -> lands at yoff=0 for exactly 1 tick, next tick yoff=3.
